// File: rtl/redmule_job_ctrl.sv
// Job controller for the matrix engine: a small FIFO of pending jobs feeding a
// five-state sequencer (IDLE, STARTING, COMPUTING, FINISHED, ABORT). The
// sequencer has a watchdog and raises done/error events to the core that
// offloaded the current job.
module redmule_job_ctrl #(
    parameter int N_CORES     = 8,
    parameter int QUEUE_DEPTH = 4,
    parameter int JOB_ID_W    = 8,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic                               abort_i,
    input  logic                               job_valid_i,
    output logic                               job_ready_o,
    input  logic [JOB_ID_W-1:0]                job_id_i,
    input  logic [$clog2(N_CORES)-1:0]         job_core_i,
    input  logic                               tiler_valid_i,
    output logic                               tiler_setback_o,
    input  logic                               w_loaded_i,
    input  logic                               z_done_i,
    input  logic [TIMEOUT_W-1:0]               timeout_i,
    output logic                               busy_o,
    output logic                               first_load_o,
    output logic                               flush_o,
    output logic                               finished_o,
    output logic                               idle_o,
    output logic                               err_o,
    output logic [N_CORES-1:0][1:0]            evt_o,
    output logic [JOB_ID_W-1:0]                cur_job_id_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_o
);

    localparam int CORE_W = $clog2(N_CORES);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STARTING  = 3'd1,
        ST_COMPUTING = 3'd2,
        ST_FINISHED  = 3'd3,
        ST_ABORT     = 3'd4
    } state_t;

    state_t              state_reg;
    logic [JOB_ID_W-1:0] id_mem   [QUEUE_DEPTH];
    logic [CORE_W-1:0]   core_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [TIMEOUT_W-1:0] wd_reg;
    logic                err_reg;
    logic [JOB_ID_W-1:0] cur_id_reg;
    logic [CORE_W-1:0]   cur_core_reg;

    logic push;
    logic pop;
    logic wd_expired;

    // Ready depends only on occupancy: a full queue never accepts, even if it pops this cycle.
    assign job_ready_o = (count_reg < CNT_W'(QUEUE_DEPTH));
    // A clear or reset in the same cycle swallows any push or pop.
    assign push        = job_valid_i && job_ready_o && !clear_i && !rst_i;
    assign pop         = (state_reg == ST_IDLE) && (count_reg != '0) && tiler_valid_i
                         && !clear_i && !rst_i;
    assign tiler_setback_o = pop;
    assign wd_expired  = (timeout_i != '0) && (wd_reg == timeout_i - TIMEOUT_W'(1));

    // Queue storage: plain array written on push, no reset needed on the data.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_reg]   <= job_id_i;
            core_mem[wr_ptr_reg] <= job_core_i;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Job sequencer with watchdog, sticky error flag and current-job latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            wd_reg       <= '0;
            err_reg      <= 1'b0;
            cur_id_reg   <= '0;
            cur_core_reg <= '0;
        end else if (clear_i) begin
            state_reg <= ST_IDLE;
            wd_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg    <= ST_STARTING;
                        wd_reg       <= '0;
                        cur_id_reg   <= id_mem[rd_ptr_reg];
                        cur_core_reg <= core_mem[rd_ptr_reg];
                    end
                end
                ST_STARTING: begin
                    wd_reg <= wd_reg + TIMEOUT_W'(1);
                    // abort beats watchdog beats the first weight load
                    if (abort_i || wd_expired) begin
                        state_reg <= ST_ABORT;
                        err_reg   <= 1'b1;
                    end else if (w_loaded_i) begin
                        state_reg <= ST_COMPUTING;
                    end
                end
                ST_COMPUTING: begin
                    wd_reg <= wd_reg + TIMEOUT_W'(1);
                    // a job that completes in the same cycle as an abort still counts as done
                    if (z_done_i) begin
                        state_reg <= ST_FINISHED;
                    end else if (abort_i || wd_expired) begin
                        state_reg <= ST_ABORT;
                        err_reg   <= 1'b1;
                    end
                end
                ST_FINISHED: state_reg <= ST_IDLE;
                ST_ABORT:    state_reg <= ST_IDLE;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_reg == ST_STARTING) || (state_reg == ST_COMPUTING);
    assign first_load_o  = (state_reg == ST_STARTING);
    assign flush_o       = (state_reg == ST_FINISHED) || (state_reg == ST_ABORT);
    assign finished_o    = (state_reg == ST_FINISHED);
    assign idle_o        = (state_reg == ST_IDLE) && (count_reg == '0);
    assign err_o         = err_reg;
    assign cur_job_id_o  = cur_id_reg;
    assign queue_count_o = count_reg;

    // Events go only to the core that owns the current job.
    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_evt
            assign evt_o[gi][0] = (state_reg == ST_FINISHED) && (cur_core_reg == CORE_W'(gi));
            assign evt_o[gi][1] = (state_reg == ST_ABORT)    && (cur_core_reg == CORE_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_redmule_job_ctrl.sv
// Randomised bench for redmule_job_ctrl: a driver issues per-job scenarios and
// predicts each job's outcome from the sequencing rules; a monitor compares the
// DUT against the expected per-cycle values and an event scoreboard.
module tb_redmule_job_ctrl;

    localparam int NC  = 8;
    localparam int QD  = 4;
    localparam int INF = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, clear_i, abort_i, job_valid_i, job_ready_o;
    logic [7:0]      job_id_i;
    logic [2:0]      job_core_i;
    logic            tiler_valid_i, tiler_setback_o, w_loaded_i, z_done_i;
    logic [15:0]     timeout_i;
    logic            busy_o, first_load_o, flush_o, finished_o, idle_o, err_o;
    logic [7:0][1:0] evt_o;
    logic [7:0]      cur_job_id_o;
    logic [2:0]      queue_count_o;

    redmule_job_ctrl #(.N_CORES(NC), .QUEUE_DEPTH(QD), .JOB_ID_W(8), .TIMEOUT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .abort_i(abort_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_id_i(job_id_i), .job_core_i(job_core_i),
        .tiler_valid_i(tiler_valid_i), .tiler_setback_o(tiler_setback_o),
        .w_loaded_i(w_loaded_i), .z_done_i(z_done_i), .timeout_i(timeout_i),
        .busy_o(busy_o), .first_load_o(first_load_o), .flush_o(flush_o),
        .finished_o(finished_o), .idle_o(idle_o), .err_o(err_o),
        .evt_o(evt_o), .cur_job_id_o(cur_job_id_o), .queue_count_o(queue_count_o)
    );

    typedef struct { logic [7:0] id; logic [2:0] core; } job_t;
    typedef struct { logic [7:0] id; logic [2:0] core; bit err; int cyc; } exp_t;

    job_t m_q[$];
    exp_t sb[$];
    bit         m_err;
    logic [7:0] m_cur_id;
    bit   pend_push, pend_pop, pend_clear, pend_rst, pend_err;
    job_t pend_job;
    bit   exp_setback, exp_busy, exp_first, exp_flush, exp_fin, exp_fsm_idle;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Opens a new cycle: commits last cycle's queue/flag effects to the model, idles the inputs.
    task automatic start_cycle();
        job_t j;
        @(posedge clk);
        #1;
        if (pend_rst) begin
            m_q.delete(); m_err = 1'b0; m_cur_id = '0;
        end else if (pend_clear) begin
            m_q.delete(); m_err = 1'b0;
        end else begin
            if (pend_pop) begin j = m_q.pop_front(); m_cur_id = j.id; end
            if (pend_push) m_q.push_back(pend_job);
            if (pend_err) m_err = 1'b1;
        end
        {pend_push, pend_pop, pend_clear, pend_rst, pend_err} = '0;
        rst_i = 0; clear_i = 0; abort_i = 0; job_valid_i = 0;
        tiler_valid_i = 0; w_loaded_i = 0; z_done_i = 0;
        job_id_i = 8'($urandom); job_core_i = 3'($urandom);
        exp_setback = 0; exp_busy = 0; exp_first = 0; exp_flush = 0; exp_fin = 0;
        exp_fsm_idle = 1;
    endtask

    task automatic offer(input logic [7:0] id, input logic [2:0] core);
        job_valid_i = 1; job_id_i = id; job_core_i = core;
        if (m_q.size() < QD) begin pend_push = 1; pend_job = '{id: id, core: core}; end
    endtask

    task automatic do_push(input int prob);
        if (int'($urandom_range(0, 99)) < prob)
            offer(8'($urandom), 3'($urandom_range(0, NC - 1)));
    endtask

    task automatic push_job(input logic [7:0] id, input logic [2:0] core);
        start_cycle();
        offer(id, core);
    endtask

    task automatic clear_cycle();
        start_cycle();
        clear_i = 1; pend_clear = 1; job_valid_i = 1;
    endtask

    // Outcome of one job from pulse indices (cycles after STARTING entry, -1 = never).
    // d = last busy cycle index, ws = last STARTING cycle index.
    function automatic void outcome(input int w, z, a, t, output int d, ws, output bit is_err);
        int tw, ww, zz, aa, zc, ac, tc;
        tw = (t == 0) ? INF : t - 1;
        ww = (w < 0) ? INF : w;
        zz = (z < 0) ? INF : z;
        aa = (a < 0) ? INF : a;
        if (ww < aa && ww < tw) begin
            ws = ww;
            zc = (zz > ww) ? zz : INF;
            ac = (aa > ww) ? aa : INF;
            tc = (tw > ww) ? tw : INF;
            d = zc;
            if (ac < d) d = ac;
            if (tc < d) d = tc;
            is_err = (zc != d);
        end else begin
            ws = INF;
            d = (aa < tw) ? aa : tw;
            is_err = 1'b1;
        end
    endfunction

    // One job from pop to completion; cut >= 0 ends it with clear (or reset) at that index.
    task automatic run_job(input int w, z, a, t, input int cut, input bit use_rst, input int prob);
        int d, ws, p;
        bit is_err;
        job_t j;
        start_cycle();
        while (m_q.size() == 0) begin do_push(100); start_cycle(); end
        j = m_q[0];
        tiler_valid_i = 1; exp_setback = 1; pend_pop = 1; timeout_i = 16'(t);
        do_push(prob);
        p = cyc;
        if (cut >= 0) begin
            d = cut; ws = (w < 0) ? INF : w; is_err = 0;
        end else begin
            outcome(w, z, a, t, d, ws, is_err);
            sb.push_back('{id: j.id, core: j.core, err: is_err, cyc: p + 2 + d});
        end
        for (int k = 0; k <= d; k++) begin
            start_cycle();
            exp_fsm_idle = 0; exp_busy = 1; exp_first = (k <= ws);
            w_loaded_i = (k == w); z_done_i = (k == z); abort_i = (k == a);
            if (k == d && cut >= 0) begin
                job_valid_i = 1;
                if (use_rst) begin rst_i = 1; pend_rst = 1; end
                else begin clear_i = 1; pend_clear = 1; end
            end else begin
                if (k == d && is_err) pend_err = 1;
                do_push(prob);
            end
        end
        if (cut < 0) begin
            start_cycle();
            exp_fsm_idle = 0; exp_flush = 1; exp_fin = !is_err;
            do_push(prob);
        end
    endtask

    // Monitor: per-cycle expectations plus event scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [15:0] ev;
        exp_t e;
        if (mon_en) begin
            check("setback", 32'(tiler_setback_o), 32'(exp_setback));
            check("busy", 32'(busy_o), 32'(exp_busy));
            check("first_load", 32'(first_load_o), 32'(exp_first));
            check("flush", 32'(flush_o), 32'(exp_flush));
            check("finished", 32'(finished_o), 32'(exp_fin));
            check("idle", 32'(idle_o), 32'(exp_fsm_idle && m_q.size() == 0));
            check("err", 32'(err_o), 32'(m_err));
            check("ready", 32'(job_ready_o), 32'(m_q.size() < QD));
            check("count", 32'(queue_count_o), 32'(m_q.size()));
            check("cur_id", 32'(cur_job_id_o), 32'(m_cur_id));
            ev = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                ev[int'(e.core) * 2 + int'(e.err)] = 1'b1;
                check("evt_job_id", 32'(cur_job_id_o), 32'(e.id));
                $display("cycle %0d: job %02h core %0d %s", cyc, e.id, e.core,
                         e.err ? "aborted" : "finished");
            end
            check("evt", 32'(evt_o), 32'(ev));
        end
    end

    initial begin
        int w, z, a, t, d, ws;
        bit e;
        rst_i = 1; clear_i = 0; abort_i = 0; job_valid_i = 0; job_id_i = 0; job_core_i = 0;
        tiler_valid_i = 0; w_loaded_i = 0; z_done_i = 0; timeout_i = 0;
        m_err = 0; m_cur_id = '0;
        {pend_push, pend_pop, pend_clear, pend_rst, pend_err} = '0;
        exp_setback = 0; exp_busy = 0; exp_first = 0; exp_flush = 0; exp_fin = 0;
        exp_fsm_idle = 1;
        repeat (2) @(posedge clk);
        #1 mon_en = 1;

        // single job to core 2
        push_job(8'h11, 3'd2);
        run_job(3, 10, -1, 0, -1, 0, 0);

        // five back-to-back pushes into a depth-4 queue, then drain in order
        for (int i = 0; i < 5; i++) push_job(8'(8'h21 + i), 3'(i));
        for (int i = 0; i < 4; i++) run_job(1, 4, -1, 0, -1, 0, 0);

        // watchdog abort, error stays set until a clear
        push_job(8'h34, 3'd5);
        run_job(-1, -1, -1, 8, -1, 0, 0);
        repeat (3) start_cycle();
        clear_cycle();

        // completion and abort in the same computing cycle
        push_job(8'h35, 3'd1);
        run_job(1, 5, 5, 0, -1, 0, 0);

        // full queue: pop with a refused push; then clear mid-computing
        for (int i = 0; i < 4; i++) push_job(8'(8'h40 + i), 3'(i + 4));
        run_job(1, -1, -1, 0, 4, 0, 100);

        // randomised jobs with background pushes and occasional clears
        for (int n = 0; n < 40; n++) begin
            do begin
                w = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 10));
                z = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
                a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
                t = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
                outcome(w, z, a, t, d, ws, e);
            end while (d >= INF);
            run_job(w, z, a, t, -1, 0, 30);
            if (n % 10 == 9) clear_cycle();
        end

        // reset mid-computing with two jobs still queued
        clear_cycle();
        for (int i = 0; i < 3; i++) push_job(8'(8'h50 + i), 3'(i));
        run_job(1, -1, -1, 0, 4, 1, 0);
        repeat (3) start_cycle();

        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
